// File: rtl/edge_event_arbiter.sv
// Edge-event arbiter: synchronizes N_IN asynchronous level inputs, detects rising edges on a
// divided sample tick, records them as pending events and hands them one at a time to a single
// consumer over a valid/ready handshake with round-robin fairness.
module edge_event_arbiter #(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TICK_DIV    = 1,
  parameter int unsigned IDW         = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] sig_in,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [IDW-1:0]  evt_id,
  output logic [N_IN-1:0] pending,
  output logic [N_IN-1:0] overflow,
  input  logic            clr_overflow
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {
    StIdle,
    StOffer
  } state_e;

  // Synchronizer chain; the last stage is the usable sampled value.
  logic [SYNC_STAGES-1:0][N_IN-1:0] sync_q, sync_d;
  // Marks which synchronizer stages hold post-reset data, so inputs held high through reset
  // are loaded into prev rather than mistaken for a rising edge.
  logic [SYNC_STAGES-1:0]           fill_q, fill_d;
  logic [N_IN-1:0]                  s;
  logic                             s_valid;

  logic [CntW-1:0]                  cnt_q, cnt_d;
  logic                             tick;

  logic [N_IN-1:0]                  prev_q, prev_d;
  logic                             armed_q, armed_d;
  logic [N_IN-1:0]                  rise;

  logic [N_IN-1:0]                  pending_q, pending_d;
  logic [N_IN-1:0]                  overflow_q, overflow_d;
  logic [N_IN-1:0]                  clearing;
  logic                             accept;

  state_e                           state_q, state_d;
  logic                             evt_valid_q, evt_valid_d;
  logic [IDW-1:0]                   evt_id_q, evt_id_d;
  logic [IDW-1:0]                   last_grant_q, last_grant_d;
  logic [IDW-1:0]                   pick;
  logic                             pick_found;

  // Synchronizer shift and fill tracking.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
    fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
    s       = sync_q[SYNC_STAGES-1];
    s_valid = fill_q[SYNC_STAGES-1];
  end

  // Sample tick divider; with TICK_DIV=1 the counter stays at 0 and tick is constant 1.
  always_comb begin
    tick  = (cnt_q == CntW'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  // Edge detection on tick; the first valid tick only loads prev and arms the detector.
  always_comb begin
    prev_d  = tick ? s : prev_q;
    armed_d = armed_q | (tick & s_valid);
    rise    = (tick && armed_q) ? (s & ~prev_q) : '0;
  end

  // Pending and overflow bookkeeping; a new edge always wins over a clear.
  always_comb begin
    accept     = (state_q == StOffer) && evt_ready;
    clearing   = accept ? (N_IN'(1) << evt_id_q) : '0;
    pending_d  = (pending_q & ~clearing) | rise;
    overflow_d = (clr_overflow ? '0 : overflow_q) | (rise & pending_q & ~clearing);
  end

  // Round-robin pick: first pending index searching upward from last_grant+1, wrapping.
  always_comb begin
    int unsigned idx;
    pick_found = 1'b0;
    pick       = '0;
    idx        = 0;
    for (int unsigned k = 1; k <= N_IN; k++) begin
      idx = (32'(last_grant_q) + k) % N_IN;
      if (!pick_found && pending_q[idx]) begin
        pick_found = 1'b1;
        pick       = IDW'(idx);
      end
    end
  end

  // Arbiter FSM next state; evt_id is only loaded in IDLE so it stays stable during OFFER.
  always_comb begin
    state_d      = state_q;
    evt_valid_d  = evt_valid_q;
    evt_id_d     = evt_id_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          evt_id_d    = pick;
          evt_valid_d = 1'b1;
          state_d     = StOffer;
        end
      end
      StOffer: begin
        if (evt_ready) begin
          last_grant_d = evt_id_q;
          evt_valid_d  = 1'b0;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        evt_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      fill_q       <= '0;
      cnt_q        <= '0;
      prev_q       <= '0;
      armed_q      <= 1'b0;
      pending_q    <= '0;
      overflow_q   <= '0;
      state_q      <= StIdle;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      last_grant_q <= IDW'(N_IN - 1);
    end else begin
      sync_q       <= sync_d;
      fill_q       <= fill_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      armed_q      <= armed_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter: one instance with TICK_DIV=1 driven by a
// vector table plus hand sequences, and a second instance with TICK_DIV=4 for tick-gated pulses.
module tb_edge_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] sig;
  logic       rdy;
  logic       clr;
  logic       valid;
  logic [1:0] id;
  logic [3:0] pend;
  logic [3:0] ovf;

  logic [3:0] sig4;
  logic       valid4;
  logic [1:0] id4;
  logic [3:0] pend4;
  logic [3:0] ovf4;

  int errors;
  int checks;

  edge_event_arbiter #(
    .N_IN(4), .SYNC_STAGES(2), .TICK_DIV(1), .IDW(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig), .evt_valid(valid), .evt_ready(rdy),
    .evt_id(id), .pending(pend), .overflow(ovf), .clr_overflow(clr)
  );

  edge_event_arbiter #(
    .N_IN(4), .SYNC_STAGES(2), .TICK_DIV(4), .IDW(2)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig4), .evt_valid(valid4), .evt_ready(1'b0),
    .evt_id(id4), .pending(pend4), .overflow(ovf4), .clr_overflow(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sig;
    logic       rdy;
    logic       clr;
    logic       exp_valid;
    logic [1:0] exp_id;
    logic [3:0] exp_pend;
    logic [3:0] exp_ovf;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] init);
    rst_n = 1'b0;
    sig   = init;
    sig4  = 4'b0000;
    rdy   = 1'b0;
    clr   = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    sig    = '0;
    sig4   = '0;
    rdy    = 1'b0;
    clr    = 1'b0;

    // Round-robin drain of three simultaneous edges, then overflow set/clear on bit 1.
    tbl[0]  = '{4'b1110, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b1110, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b1110, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1110, 4'b0000};
    tbl[3]  = '{4'b1110, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1110, 4'b0000};
    tbl[4]  = '{4'b1110, 1'b1, 1'b0, 1'b0, 2'd1, 4'b1100, 4'b0000};
    tbl[5]  = '{4'b1110, 1'b1, 1'b0, 1'b1, 2'd2, 4'b1100, 4'b0000};
    tbl[6]  = '{4'b1110, 1'b1, 1'b0, 1'b0, 2'd2, 4'b1000, 4'b0000};
    tbl[7]  = '{4'b1110, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 4'b0000};
    tbl[8]  = '{4'b1110, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b1110, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000};
    tbl[10] = '{4'b1100, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000};
    tbl[11] = '{4'b1100, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000};
    tbl[12] = '{4'b1110, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000};
    tbl[13] = '{4'b1110, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000};
    tbl[14] = '{4'b1110, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0010, 4'b0000};
    tbl[15] = '{4'b1110, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000};
    tbl[16] = '{4'b1100, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000};
    tbl[17] = '{4'b1110, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000};
    tbl[18] = '{4'b1110, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000};
    tbl[19] = '{4'b1110, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0010};
    tbl[20] = '{4'b1110, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 4'b0000};
    tbl[21] = '{4'b1110, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000};
    tbl[22] = '{4'b1110, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000};

    // Reset state, input held high through reset gives no event, then a real edge on bit 0.
    do_reset(4'b0010);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_id", id, 0);
    chk("rst_pending", pend, 0);
    chk("rst_overflow", ovf, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("held_high_no_valid", valid, 0);
    end
    chk("held_high_no_pending", pend, 0);
    sig = 4'b0011;
    step();
    step();
    chk("lat_pend_early", pend, 4'b0000);
    step();
    chk("lat_pend", pend, 4'b0001);
    chk("lat_valid_early", valid, 0);
    step();
    chk("lat_valid", valid, 1);
    chk("lat_id", id, 0);

    // Table-driven round-robin and overflow sequence.
    do_reset(4'b0000);
    repeat (5) step();
    for (int i = 0; i < 23; i++) begin
      sig = tbl[i].sig;
      rdy = tbl[i].rdy;
      clr = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d_valid", i), valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_id", i), id, tbl[i].exp_id);
      chk($sformatf("tbl%0d_pend", i), pend, tbl[i].exp_pend);
      chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].exp_ovf);
    end
    clr = 1'b0;

    // Back-pressure: offer on bit 2 held stable while bit 0 becomes pending.
    do_reset(4'b0000);
    repeat (5) step();
    sig = 4'b0100;
    repeat (3) step();
    chk("bp_pend", pend, 4'b0100);
    step();
    chk("bp_valid", valid, 1);
    chk("bp_id", id, 2);
    sig = 4'b0101;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", valid, 1);
      chk("bp_hold_id", id, 2);
    end
    chk("bp_pend_both", pend, 4'b0101);
    rdy = 1'b1;
    step();
    chk("bp_accept_valid", valid, 0);
    chk("bp_accept_pend", pend, 4'b0001);
    rdy = 1'b0;
    step();
    chk("bp_next_valid", valid, 1);
    chk("bp_next_id", id, 0);
    chk("bp_next_pend", pend, 4'b0001);

    // Edge on bit 0 lands on the same clock its event is accepted: set wins over clear.
    do_reset(4'b0000);
    repeat (5) step();
    sig = 4'b0001;
    repeat (4) step();
    chk("sw_valid", valid, 1);
    chk("sw_id", id, 0);
    sig = 4'b0000;
    repeat (3) step();
    sig = 4'b0001;
    repeat (2) step();
    rdy = 1'b1;
    step();
    chk("sw_acc_valid", valid, 0);
    chk("sw_acc_pend", pend, 4'b0001);
    chk("sw_acc_ovf", ovf, 4'b0000);
    step();
    chk("sw_regrant_valid", valid, 1);
    chk("sw_regrant_id", id, 0);
    step();
    chk("sw_done_valid", valid, 0);
    chk("sw_done_pend", pend, 4'b0000);
    rdy = 1'b0;

    // TICK_DIV=4: short pulse between ticks missed, long pulse seen once, async reset mid-offer.
    do_reset(4'b0000);
    repeat (10) step();
    sig4 = 4'b0001;
    repeat (2) step();
    sig4 = 4'b0000;
    repeat (8) step();
    chk("div_short_pend", pend4, 4'b0000);
    chk("div_short_valid", valid4, 0);
    sig4 = 4'b0001;
    repeat (6) step();
    sig4 = 4'b0000;
    repeat (2) step();
    chk("div_long_valid", valid4, 1);
    chk("div_long_id", id4, 0);
    chk("div_long_pend", pend4, 4'b0001);
    repeat (12) step();
    chk("div_once_pend", pend4, 4'b0001);
    chk("div_once_ovf", ovf4, 4'b0000);
    chk("div_once_valid", valid4, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", valid4, 0);
    chk("async_rst_pend", pend4, 4'b0000);
    step();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
